// File: rtl/ipu_stream_pkg.sv
// Shared types and constants for the binary pixel streamer.
// The optional border mask (PIX_STREAM_BORDER_MASK_EN) uses is_border().
package ipu_stream_pkg;

    localparam int                IMG_DIM   = 64;
    localparam int                ADDR_W    = 12;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 12'd4095;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic last;
        logic border;
    } tag_t;

    // Address is {row, col}; a pixel on the outer ring of the frame is a border pixel.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [5:0] row;
        logic [5:0] col;
        row = addr[11:6];
        col = addr[5:0];
        return (row == 6'd0) || (row == 6'(IMG_DIM - 1)) ||
               (col == 6'd0) || (col == 6'(IMG_DIM - 1));
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LATENCY-deep tag shift register that tracks reads in flight so each
// returning RAM word is paired with its valid/last/border flags.
module rd_tag_pipe
    import ipu_stream_pkg::*;
#(
    parameter int RD_LATENCY = 1
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_busy
);

    tag_t r_stage [RD_LATENCY];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LATENCY-1];

    always_comb begin
        o_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            o_busy = o_busy | r_stage[i].valid;
        end
    end

endmodule

// File: rtl/binary_pixel_streamer.sv
// Reads a 64x64 frame row-major from a synchronous RAM and streams one
// thresholded bit per pixel. Optional macro: PIX_STREAM_BORDER_MASK_EN.
//
// state | meaning
// IDLE  | waiting for START; threshold latched on accept
// READ  | one RAM read per unpaused cycle, addresses 0..4095
// DRAIN | waiting for in-flight reads to return
// FIN   | DONE pulse, then back to IDLE
module binary_pixel_streamer
    import ipu_stream_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int RD_LATENCY = 1
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [PIX_W-1:0]  THRESHOLD,
    input  logic              PAUSE,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [PIX_W-1:0]  RD_DATA,
    output logic              DOUT_VALID,
    output logic              DOUT,
    output logic              LAST_PIX_VALID,
    output logic              BUSY,
    output logic              DONE
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [PIX_W-1:0]  r_thr;
    logic              r_dout_valid;
    logic              r_dout;
    logic              r_last;

    logic              w_issue;
    logic              w_border;
    logic              w_pipe_busy;
    tag_t              w_tag_in;
    tag_t              w_tag_out;

    assign w_issue = (r_state == READ) && !PAUSE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_thr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_state <= READ;
                        r_cnt   <= '0;
                        r_thr   <= THRESHOLD;
                    end
                end
                READ: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_ADDR) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= FIN;
                    end
                end
                FIN:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PIX_STREAM_BORDER_MASK_EN
    assign w_border = is_border(r_cnt);
`else
    assign w_border = 1'b0;
`endif

    assign w_tag_in = tag_t'{valid:  w_issue,
                             last:   w_issue && (r_cnt == LAST_ADDR),
                             border: w_border};

    rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out),
        .o_busy (w_pipe_busy)
    );

    // RD_DATA is only meaningful when the tag at the pipe output is valid.
    always_ff @(posedge CLK) begin
        if (RST || !w_tag_out.valid) begin
            r_dout_valid <= 1'b0;
            r_dout       <= 1'b0;
            r_last       <= 1'b0;
        end else begin
            r_dout_valid <= 1'b1;
            r_dout       <= (RD_DATA > r_thr) && !w_tag_out.border;
            r_last       <= w_tag_out.last;
        end
    end

    assign RD_EN          = w_issue;
    assign RD_ADDR        = r_cnt;
    assign DOUT_VALID     = r_dout_valid;
    assign DOUT           = r_dout;
    assign LAST_PIX_VALID = r_last;
    assign BUSY           = (r_state == READ) || (r_state == DRAIN);
    assign DONE           = (r_state == FIN);

endmodule
